// File: rtl/stopwatch_btn_cmd.sv
// Push-button front end: sync, debounce, press detect, priority arbiter.
// Define BTN_TOGGLE_EN to make btn_start toggle start/stop from FSM state.
module stopwatch_btn_cmd #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_reset,
    input  logic [1:0] state,
    output logic       start,
    output logic       stop,
    output logic       reset
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       btn_raw;
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [2:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       press;
    logic             start_req, stop_req;
    logic             start_q, start_d;
    logic             stop_q, stop_d;
    logic             reset_q, reset_d;

    // Bit order: 0 start, 1 stop, 2 reset
    assign btn_raw = {btn_reset, btn_stop, btn_start};

    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = stable_d & ~stable_q;

`ifdef BTN_TOGGLE_EN
    logic toggle_stop;
    assign toggle_stop = press[0] && (state == 2'b01);
    assign start_req   = press[0] && !toggle_stop;
    assign stop_req    = press[1] || toggle_stop;
`else
    logic unused_state;
    assign unused_state = ^state;
    assign start_req    = press[0];
    assign stop_req     = press[1];
`endif

    // Fixed priority: reset > stop > start; losers are dropped
    always_comb begin
        reset_d = press[2];
        stop_d  = stop_req && !press[2];
        start_d = start_req && !stop_req && !press[2];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            reset_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            start_q  <= start_d;
            stop_q   <= stop_d;
            reset_q  <= reset_d;
        end
    end

    assign start = start_q;
    assign stop  = stop_q;
    assign reset = reset_q;

endmodule
